// File: rtl/mrv1_pkg.sv
// Shared types and default sizing for the mrv1 issue scoreboard.
package mrv1_pkg;

  localparam int unsigned NUM_THREADS_DEF = 4;
  localparam int unsigned ITAG_WIDTH_DEF  = 2;
  localparam int unsigned RF_ADDR_W_DEF   = 5;
  localparam int unsigned TWID_W_DEF      = $clog2(NUM_THREADS_DEF);

  // One itag table entry; field widths follow the package defaults.
  typedef struct packed {
    logic                     vld;
    logic [TWID_W_DEF-1:0]    twid;
    logic                     rd_vld;
    logic [RF_ADDR_W_DEF-1:0] rd_addr;
  } itag_entry_t;

endpackage

// File: rtl/mrv1_prio_enc.sv
// Lowest-set-bit priority encoder with valid flag.
module mrv1_prio_enc #(
  parameter int unsigned WIDTH_P = 4,
  localparam int unsigned IDX_W_LP = (WIDTH_P > 1) ? $clog2(WIDTH_P) : 1
) (
  input  logic [WIDTH_P-1:0]  req_i,
  output logic [IDX_W_LP-1:0] idx_o,
  output logic                vld_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    vld_o = |req_i;
    for (int unsigned i = 0; i < WIDTH_P; i++) begin
      if (req_i[WIDTH_P-1-i]) idx_o = IDX_W_LP'(WIDTH_P-1-i);
    end
  end

endmodule

// File: rtl/mrv1_scoreboard.sv
// Multithreaded in-order issue scoreboard and itag allocator.
module mrv1_scoreboard
  import mrv1_pkg::*;
#(
  parameter int unsigned NUM_THREADS_P   = NUM_THREADS_DEF,
  parameter int unsigned ITAG_WIDTH_P    = ITAG_WIDTH_DEF,
  parameter int unsigned rf_addr_width_p = RF_ADDR_W_DEF,
  localparam int unsigned twid_width_lp  = $clog2(NUM_THREADS_P),
  localparam int unsigned num_itag_lp    = 2**ITAG_WIDTH_P,
  localparam int unsigned num_rs_lp      = 2,
  localparam int unsigned num_regs_lp    = 2**rf_addr_width_p
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [twid_width_lp-1:0]   dec_twid_i,
  input  logic                       rs0_vld_i,
  input  logic [rf_addr_width_p-1:0] rs0_addr_i,
  input  logic                       rs1_vld_i,
  input  logic [rf_addr_width_p-1:0] rs1_addr_i,
  input  logic                       rd_vld_i,
  input  logic [rf_addr_width_p-1:0] rd_addr_i,
  output logic [num_rs_lp-1:0]       rs_conflict_o,
  output logic                       rd_conflict_o,
  output logic                       issue_rdy_o,
  output logic [ITAG_WIDTH_P-1:0]    issue_itag_o,
  input  logic                       issue_fire_i,
  input  logic                       retire_vld_i,
  input  logic [ITAG_WIDTH_P-1:0]    retire_itag_i,
  input  logic                       kill_vld_i,
  input  logic [ITAG_WIDTH_P-1:0]    kill_itag_i,
  output logic [ITAG_WIDTH_P:0]      inflight_cnt_o,
  output logic [NUM_THREADS_P-1:0]   thread_idle_o,
  output logic                       err_o
);

  // The entry struct is sized by the package; reject incompatible overrides.
  if (twid_width_lp != TWID_W_DEF || rf_addr_width_p != RF_ADDR_W_DEF) begin : g_width_chk
    $error("mrv1_scoreboard: thread/register widths must match mrv1_pkg");
  end

  itag_entry_t [num_itag_lp-1:0]                       entry_q, entry_d;
  logic [NUM_THREADS_P-1:0][num_regs_lp-1:0]           busy_q, busy_d;
  logic [ITAG_WIDTH_P:0]                               cnt_q, cnt_d;
  logic                                                err_q, err_d;

  logic [num_itag_lp-1:0]  free_vec;
  logic [num_itag_lp-1:0]  frees;
  logic                    issue_ok, retire_ok, kill_ok;

  mrv1_prio_enc #(.WIDTH_P(num_itag_lp)) u_free_enc (
    .req_i (free_vec),
    .idx_o (issue_itag_o),
    .vld_o (issue_rdy_o)
  );

  // Decode-facing views of registered state.
  always_comb begin
    for (int unsigned i = 0; i < num_itag_lp; i++) free_vec[i] = ~entry_q[i].vld;
    rs_conflict_o[0] = rs0_vld_i && busy_q[dec_twid_i][rs0_addr_i];
    rs_conflict_o[1] = rs1_vld_i && busy_q[dec_twid_i][rs1_addr_i];
    rd_conflict_o    = rd_vld_i && busy_q[dec_twid_i][rd_addr_i];
    thread_idle_o    = '1;
    for (int unsigned i = 0; i < num_itag_lp; i++) begin
      if (entry_q[i].vld) thread_idle_o[entry_q[i].twid] = 1'b0;
    end
  end

  // Next-state: frees first, then allocation, so an issue's busy set wins.
  always_comb begin
    issue_ok  = issue_fire_i && issue_rdy_o;
    retire_ok = retire_vld_i && entry_q[retire_itag_i].vld;
    kill_ok   = kill_vld_i && entry_q[kill_itag_i].vld;
    err_d     = err_q
              | (retire_vld_i && !entry_q[retire_itag_i].vld)
              | (kill_vld_i && !entry_q[kill_itag_i].vld)
              | (issue_fire_i && !issue_rdy_o);

    // Retire and kill of the same itag collapse to one free here.
    for (int unsigned i = 0; i < num_itag_lp; i++) begin
      frees[i] = (retire_ok && retire_itag_i == ITAG_WIDTH_P'(i))
              || (kill_ok && kill_itag_i == ITAG_WIDTH_P'(i));
    end

    entry_d = entry_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    for (int unsigned i = 0; i < num_itag_lp; i++) begin
      if (frees[i]) begin
        entry_d[i].vld = 1'b0;
        if (entry_q[i].rd_vld) busy_d[entry_q[i].twid][entry_q[i].rd_addr] = 1'b0;
        cnt_d = cnt_d - 1'b1;
      end
    end

    if (issue_ok) begin
      entry_d[issue_itag_o].vld     = 1'b1;
      entry_d[issue_itag_o].twid    = dec_twid_i;
      entry_d[issue_itag_o].rd_vld  = rd_vld_i;
      entry_d[issue_itag_o].rd_addr = rd_addr_i;
      if (rd_vld_i && rd_addr_i != '0) busy_d[dec_twid_i][rd_addr_i] = 1'b1;
      cnt_d = cnt_d + 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      entry_q <= '0;
      busy_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      entry_q <= entry_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign inflight_cnt_o = cnt_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_mrv1_scoreboard.sv
// Directed self-checking bench for mrv1_scoreboard (4 threads, 4 itags).
module tb_mrv1_scoreboard;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [1:0] dec_twid_i;
  logic       rs0_vld_i, rs1_vld_i, rd_vld_i;
  logic [4:0] rs0_addr_i, rs1_addr_i, rd_addr_i;
  logic [1:0] rs_conflict_o;
  logic       rd_conflict_o;
  logic       issue_rdy_o;
  logic [1:0] issue_itag_o;
  logic       issue_fire_i;
  logic       retire_vld_i, kill_vld_i;
  logic [1:0] retire_itag_i, kill_itag_i;
  logic [2:0] inflight_cnt_o;
  logic [3:0] thread_idle_o;
  logic       err_o;

  int total = 0;
  int bad   = 0;

  mrv1_scoreboard #(
    .NUM_THREADS_P   (4),
    .ITAG_WIDTH_P    (2),
    .rf_addr_width_p (5)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .dec_twid_i     (dec_twid_i),
    .rs0_vld_i      (rs0_vld_i),
    .rs0_addr_i     (rs0_addr_i),
    .rs1_vld_i      (rs1_vld_i),
    .rs1_addr_i     (rs1_addr_i),
    .rd_vld_i       (rd_vld_i),
    .rd_addr_i      (rd_addr_i),
    .rs_conflict_o  (rs_conflict_o),
    .rd_conflict_o  (rd_conflict_o),
    .issue_rdy_o    (issue_rdy_o),
    .issue_itag_o   (issue_itag_o),
    .issue_fire_i   (issue_fire_i),
    .retire_vld_i   (retire_vld_i),
    .retire_itag_i  (retire_itag_i),
    .kill_vld_i     (kill_vld_i),
    .kill_itag_i    (kill_itag_i),
    .inflight_cnt_o (inflight_cnt_o),
    .thread_idle_o  (thread_idle_o),
    .err_o          (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then drop all one-cycle strobes.
  task automatic tick();
    @(posedge clk_i);
    #1;
    issue_fire_i = 1'b0;
    retire_vld_i = 1'b0;
    kill_vld_i   = 1'b0;
    rst_i        = 1'b0;
  endtask

  task automatic query(input logic [1:0] tw, input logic r0v, input logic [4:0] r0,
                       input logic r1v, input logic [4:0] r1,
                       input logic rdv, input logic [4:0] rd);
    dec_twid_i = tw;
    rs0_vld_i = r0v; rs0_addr_i = r0;
    rs1_vld_i = r1v; rs1_addr_i = r1;
    rd_vld_i  = rdv; rd_addr_i  = rd;
    #1;
  endtask

  task automatic issue(input logic [1:0] tw, input logic [4:0] rd);
    query(tw, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, rd);
    issue_fire_i = 1'b1;
  endtask

  initial begin
    rst_i = 1'b1;
    issue_fire_i = 1'b0; retire_vld_i = 1'b0; kill_vld_i = 1'b0;
    retire_itag_i = '0; kill_itag_i = '0;
    query(2'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    tick();

    // Reset values
    query(2'd1, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd5);
    chk("rst_rdy",  issue_rdy_o, 1);
    chk("rst_itag", issue_itag_o, 0);
    chk("rst_cnt",  inflight_cnt_o, 0);
    chk("rst_idle", thread_idle_o, 4'hF);
    chk("rst_err",  err_o, 0);
    chk("rst_rs",   rs_conflict_o, 0);
    chk("rst_rd",   rd_conflict_o, 0);

    // t1 writes x5 -> itag 0
    issue(2'd1, 5'd5); tick();
    query(2'd1, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd5);
    chk("t1_rs",    rs_conflict_o, 2'b01);
    chk("t1_rd",    rd_conflict_o, 1);
    chk("t1_itag",  issue_itag_o, 1);
    chk("t1_cnt",   inflight_cnt_o, 1);
    chk("t1_idle",  thread_idle_o, 4'b1101);
    query(2'd2, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd5);
    chk("t2_rs",    rs_conflict_o, 2'b00);
    chk("t2_rd",    rd_conflict_o, 0);

    // t2 writes x0 -> itag 1, no busy bit
    issue(2'd2, 5'd0); tick();
    query(2'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    chk("x0_rs",    rs_conflict_o, 0);
    chk("x0_itag",  issue_itag_o, 2);

    // Fill: t0 x7 -> itag 2, t3 x9 -> itag 3
    issue(2'd0, 5'd7); tick();
    issue(2'd3, 5'd9); tick();
    chk("full_rdy",  issue_rdy_o, 0);
    chk("full_cnt",  inflight_cnt_o, 4);
    chk("full_idle", thread_idle_o, 4'b0000);

    // Retire itag 2; conflict still visible in the retire cycle
    retire_vld_i = 1'b1; retire_itag_i = 2'd2;
    query(2'd0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 5'd0);
    chk("ret_same_cyc", rs_conflict_o, 2'b10);
    chk("ret_same_rdy", issue_rdy_o, 0);
    tick();
    query(2'd0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 5'd0);
    chk("ret_rdy",   issue_rdy_o, 1);
    chk("ret_itag",  issue_itag_o, 2);
    chk("ret_cnt",   inflight_cnt_o, 3);
    chk("ret_idle",  thread_idle_o, 4'b0001);
    chk("ret_rs",    rs_conflict_o, 0);

    // Free itag 1, issue t0 x7 into it, then retire it while reissuing t0 x7
    retire_vld_i = 1'b1; retire_itag_i = 2'd1; tick();
    issue(2'd0, 5'd7); tick();
    chk("lowfree_cnt", inflight_cnt_o, 3);
    retire_vld_i = 1'b1; retire_itag_i = 2'd1;
    issue(2'd0, 5'd7); tick();
    query(2'd0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0);
    chk("setwin_rs",   rs_conflict_o, 2'b01);
    chk("setwin_cnt",  inflight_cnt_o, 3);
    chk("setwin_itag", issue_itag_o, 1);
    retire_vld_i = 1'b1; retire_itag_i = 2'd2; tick();
    query(2'd0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0);
    chk("newown_rs",   rs_conflict_o, 0);
    chk("newown_idle", thread_idle_o, 4'b0101);

    // t2 x3 -> itag 1; then kill 3 and retire 1 together
    issue(2'd2, 5'd3); tick();
    chk("pre_kill_cnt", inflight_cnt_o, 3);
    kill_vld_i = 1'b1; kill_itag_i = 2'd3;
    retire_vld_i = 1'b1; retire_itag_i = 2'd1; tick();
    chk("kr_cnt",  inflight_cnt_o, 1);
    chk("kr_idle", thread_idle_o, 4'b1101);
    query(2'd3, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0);
    chk("kr_t3",   rs_conflict_o, 0);
    query(2'd2, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0);
    chk("kr_t2",   rs_conflict_o, 0);
    query(2'd1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
    chk("kr_t1",   rs_conflict_o, 2'b01);
    chk("kr_err",  err_o, 0);

    // Retire and kill the same itag: one free, no error
    kill_vld_i = 1'b1; kill_itag_i = 2'd0;
    retire_vld_i = 1'b1; retire_itag_i = 2'd0; tick();
    chk("dup_cnt",  inflight_cnt_o, 0);
    chk("dup_idle", thread_idle_o, 4'hF);
    chk("dup_err",  err_o, 0);

    // Retire of an unallocated itag: sticky error, no state change
    retire_vld_i = 1'b1; retire_itag_i = 2'd2; tick();
    chk("uerr_err",  err_o, 1);
    chk("uerr_cnt",  inflight_cnt_o, 0);
    chk("uerr_itag", issue_itag_o, 0);
    tick();
    chk("uerr_sticky", err_o, 1);

    // Reset mid-stream with an issue pending
    issue(2'd1, 5'd5); tick();
    issue(2'd1, 5'd6); rst_i = 1'b1; tick();
    query(2'd1, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd6);
    chk("mrst_cnt",  inflight_cnt_o, 0);
    chk("mrst_err",  err_o, 0);
    chk("mrst_idle", thread_idle_o, 4'hF);
    chk("mrst_rs",   rs_conflict_o, 0);
    chk("mrst_rd",   rd_conflict_o, 0);
    chk("mrst_itag", issue_itag_o, 0);

    // Issue while full is an error and is ignored
    for (int i = 0; i < 4; i++) begin
      issue(2'(i), 5'(i + 1)); tick();
    end
    chk("ovf_pre_err", err_o, 0);
    issue(2'd0, 5'd20); tick();
    chk("ovf_err", err_o, 1);
    chk("ovf_cnt", inflight_cnt_o, 4);
    query(2'd0, 1'b1, 5'd20, 1'b1, 5'd1, 1'b0, 5'd0);
    chk("ovf_rs",  rs_conflict_o, 2'b10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/mrv1_scoreboard.md
# mrv1_scoreboard

In-order multithreaded issue scoreboard and itag allocator for the mrv1 core. It sits between decode and the issue queue/execution units. It tracks, per hardware thread, which architectural registers have an in-flight producer, and generates the per-source conflict vector decode consumes. It owns the pool of instruction tags (itags): one is allocated on every issue and freed on retire or kill.

## Interface
Parameters:
- NUM_THREADS_P, 4, hardware threads (power of 2, ≥2); twid_width_lp = $clog2(NUM_THREADS_P)
- ITAG_WIDTH_P, 2, itag width; itag pool depth num_itag_lp = 2**ITAG_WIDTH_P
- rf_addr_width_p, 5, register address width
- num_rs_lp, 2, source operands per instruction (local, fixed)

Ports:
- clk_i  in  1  clock; all state on rising edge
- rst_i  in  1  reset; synchronous, active-high
- dec_twid_i  in  twid_width_lp  thread of instruction in decode
- rs0_vld_i / rs1_vld_i  in  1 each  source operand used
- rs0_addr_i / rs1_addr_i  in  rf_addr_width_p each  source register
- rd_vld_i  in  1  instruction writes rd
- rd_addr_i  in  rf_addr_width_p  destination register
- rs_conflict_o  out  num_rs_lp  bit i = source i has in-flight producer
- rd_conflict_o  out  1  rd has in-flight producer (WAW)
- issue_rdy_o  out  1  free itag available
- issue_itag_o  out  ITAG_WIDTH_P  itag granted on issue this cycle
- issue_fire_i  in  1  decode issues this cycle (issue_vld & issue_rdy)
- retire_vld_i  in  1  instruction retires
- retire_itag_i  in  ITAG_WIDTH_P  itag of retiring instruction
- kill_vld_i  in  1  squash in-flight instruction (branch flush)
- kill_itag_i  in  ITAG_WIDTH_P  itag of squashed instruction
- inflight_cnt_o  out  ITAG_WIDTH_P+1  allocated itags
- thread_idle_o  out  NUM_THREADS_P  bit t = thread t has no allocated itag
- err_o  out  1  sticky: retire/kill of unallocated itag, or issue_fire_i while !issue_rdy_o

## Operation
- Itag table, num_itag_lp entries: {vld, twid, rd_vld, rd_addr}. Busy array: NUM_THREADS_P × 2**rf_addr_width_p bits.
- Allocation: issue_itag_o = lowest-index entry with vld=0; issue_rdy_o = any entry free. On issue_fire_i the entry is written with vld=1, dec_twid_i, rd_vld_i, rd_addr_i.
- Busy set on issue_fire_i when rd_vld_i && rd_addr_i!=0: busy[dec_twid_i][rd_addr_i]←1. Register 0 is never busy.
- Retire or kill of a valid entry: vld←0; if its rd_vld, busy[twid][rd_addr]←0. Kill and retire behave identically (no writeback distinction here).
- Conflict: rs_conflict_o[i] = rsi_vld_i && busy[dec_twid_i][rsi_addr_i]. rd_conflict_o = rd_vld_i && busy[dec_twid_i][rd_addr_i]. Purely combinational from registered state.
- Simultaneous events, same cycle:
  - Retire and kill of different itags: both processed.
  - Retire and kill of same itag: processed once, no error.
  - Issue setting and retire clearing the same busy bit: set wins.
- Entry freed in cycle N is allocatable from cycle N+1 (no same-cycle reuse).
- inflight_cnt_o = popcount of entry vld bits, registered: +1 on issue, −1 per distinct valid free.
- thread_idle_o[t] = no vld entry with twid==t.
- err_o: set on any error condition; cleared only by rst_i. Erroneous retire/kill alters no state. Erroneous issue is ignored.
- Reset: all entries invalid, busy all 0, issue_rdy_o=1, issue_itag_o=0, rs_conflict_o=0, rd_conflict_o=0, inflight_cnt_o=0, thread_idle_o all 1, err_o=0.

## Timing
- Conflict/rdy/itag outputs are combinational from state: zero latency to decode inputs.
- Issue, retire and kill effects are visible the cycle after the event.
- A retire in cycle N does not clear conflict in cycle N; decode relies on its bypass path for same-cycle forwarding.
- Full: with all entries valid, issue_rdy_o=0; it rises the cycle after the first retire/kill.
- rst_i asserted mid-operation discards all in-flight state at the next edge.

## Structure
- Shared package mrv1_pkg holds:
  - itag entry struct
  - the default NUM_THREADS_P / ITAG_WIDTH_P constants
- One sub-module, mrv1_prio_enc: parameterised lowest-set-bit encoder with valid output. It is used for free-itag selection.

## Test plan
- Reset, then thread 1 issues rd=x5 (itag 0). Next cycle, decode thread 1 with rs0=x5 -> rs_conflict_o=2'b01, issue_itag_o=1. Same query as thread 2 -> rs_conflict_o=0.
- Issue 4 instructions (ITAG_WIDTH_P=2) -> issue_rdy_o=0, inflight_cnt_o=4. Retire itag 2 -> next cycle issue_rdy_o=1, issue_itag_o=2.
- Issue with rd=x0 -> no busy bit. Later rs0=x0 query -> rs_conflict_o[0]=0.
- Same cycle: retire itag 0 (t0, rd x7) and issue t0 rd=x7 -> x7 busy next cycle, owned by new itag. Retiring the new itag clears it.
- Kill itag 3 and retire itag 1 in the same cycle -> both freed, inflight_cnt_o drops by 2, thread_idle_o updates per twid.
- Retire of an unallocated itag -> err_o=1 and stays 1, no state change. rst_i mid-stream -> all reset values next cycle.
